// File: rtl/mips_regfile_sb.sv
// MIPS32 register file with a per-register write-pending scoreboard.
// A source with an outstanding write stalls issue unless the completing writeback is bypassed.
module mips_regfile_sb #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int AW    = 5,
  parameter int CW    = 2
) (
  input  logic             clk1,
  input  logic             reset,
  input  logic             issue_valid,
  input  logic [AW-1:0]    issue_rs,
  input  logic [AW-1:0]    issue_rt,
  input  logic             issue_use_rs,
  input  logic             issue_use_rt,
  input  logic             issue_we,
  input  logic [AW-1:0]    issue_rd,
  output logic             stall,
  output logic             op_valid,
  output logic [XLEN-1:0]  rs_data,
  output logic [XLEN-1:0]  rt_data,
  input  logic             wb_valid,
  input  logic [AW-1:0]    wb_rd,
  input  logic [XLEN-1:0]  wb_data,
  input  logic             flush,
  output logic [NREGS-1:0] busy_mask,
  output logic             wb_err
);

  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};
  localparam logic [AW-1:0] IDX_ZERO = {AW{1'b0}};

  logic [XLEN-1:0]  r_regs [NREGS];
  logic [CW-1:0]    r_cnt  [NREGS];

  logic             w_rs_haz;
  logic             w_rt_haz;
  logic             w_rd_haz;
  logic             w_fire;
  logic [XLEN-1:0]  w_rs_val;
  logic [XLEN-1:0]  w_rt_val;
  logic [NREGS-1:0] w_inc;
  logic [NREGS-1:0] w_dec;

  // A lone pending write that retires this very cycle is forwarded, so it is not a hazard.
  function automatic logic src_hazard(input logic use_src, input logic [AW-1:0] src,
                                      input logic [CW-1:0] cnt, input logic wv,
                                      input logic [AW-1:0] wrd);
    logic byp;
    byp = (cnt == CNT_ONE) && wv && (wrd == src);
    return use_src && (src != IDX_ZERO) && (cnt != CNT_ZERO) && !byp;
  endfunction

  function automatic logic [XLEN-1:0] read_op(input logic [AW-1:0] src, input logic wv,
                                              input logic [AW-1:0] wrd,
                                              input logic [XLEN-1:0] wd,
                                              input logic [XLEN-1:0] stored);
    logic [XLEN-1:0] val;
    if (src == IDX_ZERO) begin
      val = {XLEN{1'b0}};
    end else if (wv && (wrd == src)) begin
      val = wd;
    end else begin
      val = stored;
    end
    return val;
  endfunction

  // Hazard detection, issue acceptance and operand selection.
  always_comb begin
    w_rs_haz = src_hazard(issue_use_rs, issue_rs, r_cnt[issue_rs], wb_valid, wb_rd);
    w_rt_haz = src_hazard(issue_use_rt, issue_rt, r_cnt[issue_rt], wb_valid, wb_rd);
    w_rd_haz = issue_we && (issue_rd != IDX_ZERO) && (r_cnt[issue_rd] == CNT_MAX);
    stall    = issue_valid && (w_rs_haz || w_rt_haz || w_rd_haz);
    w_fire   = issue_valid && !stall;
    w_rs_val = read_op(issue_rs, wb_valid, wb_rd, wb_data, r_regs[issue_rs]);
    w_rt_val = read_op(issue_rt, wb_valid, wb_rd, wb_data, r_regs[issue_rt]);
  end

  // Per-register increment/decrement requests and the busy view of the counters.
  always_comb begin
    w_inc     = {NREGS{1'b0}};
    w_dec     = {NREGS{1'b0}};
    busy_mask = {NREGS{1'b0}};
    for (int i = 1; i < NREGS; i++) begin
      w_inc[i]     = w_fire && issue_we && (issue_rd == AW'(i));
      w_dec[i]     = wb_valid && (wb_rd == AW'(i)) && (r_cnt[i] != CNT_ZERO);
      busy_mask[i] = (r_cnt[i] != CNT_ZERO);
    end
  end

  // Pending-write counters; flush wins over any increment or decrement.
  always_ff @(posedge clk1 or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) r_cnt[i] <= CNT_ZERO;
    end else if (flush) begin
      for (int i = 0; i < NREGS; i++) r_cnt[i] <= CNT_ZERO;
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (w_inc[i] && !w_dec[i]) begin
          r_cnt[i] <= r_cnt[i] + CNT_ONE;
        end else if (w_dec[i] && !w_inc[i]) begin
          r_cnt[i] <= r_cnt[i] - CNT_ONE;
        end else begin
          r_cnt[i] <= r_cnt[i];
        end
      end
    end
  end

  // Architectural registers; R0 is never written so it stays zero.
  always_ff @(posedge clk1 or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= {XLEN{1'b0}};
    end else if (wb_valid && (wb_rd != IDX_ZERO)) begin
      r_regs[wb_rd] <= wb_data;
    end
  end

  // Operand latch, one cycle after an accepted issue.
  always_ff @(posedge clk1 or posedge reset) begin
    if (reset) begin
      op_valid <= 1'b0;
      rs_data  <= {XLEN{1'b0}};
      rt_data  <= {XLEN{1'b0}};
    end else begin
      op_valid <= w_fire;
      if (w_fire) begin
        rs_data <= w_rs_val;
        rt_data <= w_rt_val;
      end
    end
  end

  // Sticky flag for a writeback nobody was waiting for.
  always_ff @(posedge clk1 or posedge reset) begin
    if (reset) begin
      wb_err <= 1'b0;
    end else if (wb_valid && (wb_rd != IDX_ZERO) && (r_cnt[wb_rd] == CNT_ZERO)) begin
      wb_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mips_regfile_sb.sv
// Random and directed bench for mips_regfile_sb with a queue-based operand scoreboard.
module tb_mips_regfile_sb;

  logic        clk1 = 1'b0;
  logic        reset = 1'b1;
  logic        issue_valid = 1'b0;
  logic [4:0]  issue_rs = 5'd0;
  logic [4:0]  issue_rt = 5'd0;
  logic        issue_use_rs = 1'b0;
  logic        issue_use_rt = 1'b0;
  logic        issue_we = 1'b0;
  logic [4:0]  issue_rd = 5'd0;
  logic        stall;
  logic        op_valid;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        wb_valid = 1'b0;
  logic [4:0]  wb_rd = 5'd0;
  logic [31:0] wb_data = 32'd0;
  logic        flush = 1'b0;
  logic [31:0] busy_mask;
  logic        wb_err;

  mips_regfile_sb dut (
    .clk1(clk1), .reset(reset), .issue_valid(issue_valid), .issue_rs(issue_rs),
    .issue_rt(issue_rt), .issue_use_rs(issue_use_rs), .issue_use_rt(issue_use_rt),
    .issue_we(issue_we), .issue_rd(issue_rd), .stall(stall), .op_valid(op_valid),
    .rs_data(rs_data), .rt_data(rt_data), .wb_valid(wb_valid), .wb_rd(wb_rd),
    .wb_data(wb_data), .flush(flush), .busy_mask(busy_mask), .wb_err(wb_err)
  );

  always #5 clk1 = ~clk1;

  typedef struct { logic [31:0] rs; logic [31:0] rt; } op_t;
  op_t exp_q[$];

  int          total = 0;
  int          bad = 0;
  int          cnt_m [32];
  logic [31:0] mem_m [32];
  bit          err_m;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  function automatic bit src_haz(bit u, int s, bit wv, int wrd);
    if (!u || s == 0 || cnt_m[s] == 0) return 1'b0;
    return !(cnt_m[s] == 1 && wv && wrd == s);
  endfunction

  function automatic logic [31:0] op_val(int s, bit wv, int wrd, logic [31:0] wd);
    if (s == 0) return 32'd0;
    if (wv && wrd == s) return wd;
    return mem_m[s];
  endfunction

  // Monitor: every operand the DUT presents must match the oldest expected entry.
  always @(posedge clk1) begin
    #1;
    if (!reset && op_valid) begin
      if (exp_q.size() == 0) begin
        chk("op_unexpected", {31'd0, op_valid}, 32'd0);
      end else begin
        op_t e;
        e = exp_q.pop_front();
        chk("op_rs", rs_data, e.rs);
        chk("op_rt", rt_data, e.rt);
      end
    end
  end

  task automatic cycle(input bit iv, input int a_rs, input int a_rt, input bit urs,
                       input bit urt, input bit we, input int rd, input bit wv,
                       input int wrd, input logic [31:0] wd, input bit fl);
    bit          exp_stall;
    bit          fire;
    bit          dec;
    logic [31:0] mask;
    op_t         e;
    @(negedge clk1);
    issue_valid = iv; issue_rs = 5'(a_rs); issue_rt = 5'(a_rt);
    issue_use_rs = urs; issue_use_rt = urt; issue_we = we; issue_rd = 5'(rd);
    wb_valid = wv; wb_rd = 5'(wrd); wb_data = wd; flush = fl;
    #1;
    exp_stall = iv && (src_haz(urs, a_rs, wv, wrd) || src_haz(urt, a_rt, wv, wrd) ||
                       (we && rd != 0 && cnt_m[rd] == 3));
    mask = 32'd0;
    for (int r = 1; r < 32; r++) mask[r] = (cnt_m[r] != 0);
    chk("stall", {31'd0, stall}, {31'd0, exp_stall});
    chk("busy_mask", busy_mask, mask);
    chk("wb_err", {31'd0, wb_err}, {31'd0, err_m});
    fire = iv && !exp_stall;
    if (fire) begin
      e.rs = op_val(a_rs, wv, wrd, wd);
      e.rt = op_val(a_rt, wv, wrd, wd);
      exp_q.push_back(e);
    end
    dec = wv && wrd != 0 && cnt_m[wrd] != 0;
    if (wv && wrd != 0) begin
      if (cnt_m[wrd] == 0) err_m = 1'b1;
      mem_m[wrd] = wd;
    end
    if (fl) begin
      for (int r = 0; r < 32; r++) cnt_m[r] = 0;
    end else begin
      if (dec) cnt_m[wrd]--;
      if (fire && we && rd != 0) cnt_m[rd]++;
    end
  endtask

  task automatic idle();
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'd0, 0);
  endtask

  task automatic preload(input int r, input logic [31:0] v);
    cycle(1, 0, 0, 0, 0, 1, r, 0, 0, 32'd0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 1, r, v, 0);
  endtask

  task automatic do_reset();
    issue_valid = 1'b0; wb_valid = 1'b0; flush = 1'b0; issue_we = 1'b0;
    issue_use_rs = 1'b0; issue_use_rt = 1'b0;
    reset = 1'b1;
    #1;
    chk("rst_op_valid", {31'd0, op_valid}, 32'd0);
    chk("rst_rs_data", rs_data, 32'd0);
    chk("rst_rt_data", rt_data, 32'd0);
    chk("rst_busy", busy_mask, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_wb_err", {31'd0, wb_err}, 32'd0);
    for (int r = 0; r < 32; r++) begin cnt_m[r] = 0; mem_m[r] = 32'd0; end
    err_m = 1'b0;
    exp_q.delete();
    @(negedge clk1);
    #2 reset = 1'b0;
  endtask

  initial begin
    int pend[$];
    bit wv;
    int wrd;
    do_reset();

    for (int n = 0; n < 400; n++) begin
      pend.delete();
      for (int r = 1; r < 32; r++) if (cnt_m[r] > 0) pend.push_back(r);
      wv  = (pend.size() > 0) && ($urandom_range(0, 1) == 1);
      wrd = wv ? pend[$urandom_range(0, pend.size() - 1)] : $urandom_range(0, 31);
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 7),
            $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
            $urandom_range(0, 7), wv, wrd, $urandom, $urandom_range(0, 39) == 0);
    end
    idle();

    // Reset in the middle of activity.
    do_reset();
    cycle(1, 0, 0, 0, 0, 1, 3, 0, 0, 32'd0, 0);
    cycle(1, 0, 0, 1, 0, 1, 3, 0, 0, 32'd0, 0);
    @(posedge clk1); #1;
    chk("mid_op_valid", {31'd0, op_valid}, 32'd1);
    chk("mid_busy3", busy_mask, 32'h0000_0008);
    #1;
    do_reset();
    idle();

    // RAW stall then bypass.
    preload(2, 32'd20);
    cycle(1, 0, 0, 0, 0, 1, 1, 0, 0, 32'd0, 0);
    cycle(1, 1, 2, 1, 1, 1, 4, 0, 0, 32'd0, 0);
    chk("raw_stall", {31'd0, stall}, 32'd1);
    chk("raw_busy1", {31'd0, busy_mask[1]}, 32'd1);
    cycle(1, 1, 2, 1, 1, 1, 4, 1, 1, 32'd10, 0);
    chk("raw_bypass_stall", {31'd0, stall}, 32'd0);
    @(posedge clk1); #1;
    chk("raw_op_valid", {31'd0, op_valid}, 32'd1);
    chk("raw_rs", rs_data, 32'd10);
    chk("raw_rt", rt_data, 32'd20);

    // Dependent chain through R4.
    preload(3, 32'd25);
    cycle(1, 4, 3, 1, 1, 1, 5, 0, 0, 32'd0, 0);
    chk("chain_stall", {31'd0, stall}, 32'd1);
    cycle(1, 4, 3, 1, 1, 1, 5, 1, 4, 32'd30, 0);
    @(posedge clk1); #1;
    chk("chain_rs", rs_data, 32'd30);
    chk("chain_rt", rt_data, 32'd25);
    cycle(0, 0, 0, 0, 0, 0, 0, 1, 5, 32'd55, 0);

    // WAW saturation on R7.
    for (int k = 0; k < 3; k++) cycle(1, 0, 0, 0, 0, 1, 7, 0, 0, 32'd0, 0);
    cycle(1, 0, 0, 0, 0, 1, 7, 0, 0, 32'd0, 0);
    chk("waw_sat_stall", {31'd0, stall}, 32'd1);
    cycle(1, 0, 0, 0, 0, 1, 7, 1, 7, 32'd77, 0);
    chk("waw_wb_cycle_stall", {31'd0, stall}, 32'd1);
    cycle(1, 0, 0, 0, 0, 1, 7, 0, 0, 32'd0, 0);
    chk("waw_accept", {31'd0, stall}, 32'd0);
    for (int k = 0; k < 3; k++) cycle(0, 0, 0, 0, 0, 0, 0, 1, 7, 32'd70 + 32'(k), 0);

    // R0 writes are discarded; concurrent issue+wb on R5 keeps the count.
    cycle(1, 0, 0, 1, 1, 0, 0, 1, 0, 32'hFFFF_FFFF, 0);
    @(posedge clk1); #1;
    chk("r0_rs", rs_data, 32'd0);
    cycle(1, 0, 0, 0, 0, 1, 5, 0, 0, 32'd0, 0);
    cycle(1, 0, 0, 0, 0, 1, 5, 1, 5, 32'd5, 0);
    idle();
    chk("simul_busy5", {31'd0, busy_mask[5]}, 32'd1);
    cycle(0, 0, 0, 0, 0, 0, 0, 1, 5, 32'd6, 0);
    idle();

    // Flush then an orphan writeback.
    cycle(1, 0, 0, 0, 0, 1, 2, 0, 0, 32'd0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'd0, 1);
    idle();
    chk("flush_busy", busy_mask, 32'd0);
    cycle(0, 0, 0, 0, 0, 0, 0, 1, 2, 32'h55, 0);
    cycle(1, 2, 0, 1, 0, 0, 0, 0, 0, 32'd0, 0);
    chk("err_set", {31'd0, wb_err}, 32'd1);
    @(posedge clk1); #1;
    chk("err_reg2", rs_data, 32'h55);
    for (int k = 0; k < 4; k++) idle();
    chk("err_sticky", {31'd0, wb_err}, 32'd1);
    do_reset();
    idle();
    idle();
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
